// File: rtl/audio_pwm_out.sv
// Audio output stage: buffers unsigned PCM samples in a small FIFO and plays one
// sample per PWM period, with a per-period pacing tick and underrun reporting.
module audio_pwm_out #(
  parameter  int SAMPLE_W   = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int UCNT_W     = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                aud_pwm,
  output logic                aud_sd,
  output logic                period_tick,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt,
  output logic [LVL_W-1:0]    fifo_level
);

  localparam int                  PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [SAMPLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] duty_q, duty_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
  logic                pwm_q, pwm_d;
  logic                sd_q;

  logic full, empty, boundary, push, pop, under;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  // Gating with rst keeps the combinational pulses quiet during a mid-period reset.
  assign boundary = enable && !rst && (cnt_q == CNT_MAX);
  assign push     = in_valid && !full && !rst;
  assign pop      = boundary && !empty;
  assign under    = boundary && empty;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d    = enable ? cnt_q + SAMPLE_W'(1) : '0;
    duty_d   = duty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ucnt_d   = ucnt_q;
    pwm_d    = enable && (cnt_q < duty_q);

    if (!enable) begin
      duty_d = '0;
    end else if (pop) begin
      duty_d = mem_q[rd_ptr_q];
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (under && (ucnt_q != '1)) ucnt_d = ucnt_q + UCNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      ucnt_q   <= '0;
      pwm_q    <= 1'b0;
      sd_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      ucnt_q   <= ucnt_d;
      pwm_q    <= pwm_d;
      sd_q     <= enable;
    end
  end

  // NOTE: the sample storage is not reset; the level and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready     = !full;
  assign aud_pwm      = pwm_q;
  assign aud_sd       = sd_q;
  assign period_tick  = boundary;
  assign underrun     = under;
  assign underrun_cnt = ucnt_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: a scoreboard of pushed samples is checked
// against the measured high count of each PWM period, plus cycle-level handshake checks.
module tb_audio_pwm_out;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst, enable, in_valid, in_ready;
  logic [SW-1:0] in_data;
  logic          aud_pwm, aud_sd, period_tick, underrun;
  logic [7:0]    underrun_cnt;
  logic [2:0]    fifo_level;

  logic          rst2, en2, in_valid2, in_ready2;
  logic [SW-1:0] in_data2;
  logic          aud_pwm2, aud_sd2, period_tick2, underrun2;
  logic [1:0]    ucnt2;
  logic [2:0]    level2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] discard;
  logic          pwm_seen;
  logic          win_on = 1'b0, tick_d = 1'b0, pop_d = 1'b0;
  int            acc = 0;

  always #5 clk = ~clk;

  audio_pwm_out #(.SAMPLE_W(SW), .FIFO_DEPTH(4), .UCNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .aud_pwm(aud_pwm), .aud_sd(aud_sd), .period_tick(period_tick),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
  );

  audio_pwm_out #(.SAMPLE_W(SW), .FIFO_DEPTH(4), .UCNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst2), .enable(en2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .aud_pwm(aud_pwm2), .aud_sd(aud_sd2), .period_tick(period_tick2),
    .underrun(underrun2), .underrun_cnt(ucnt2), .fifo_level(level2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Measures aud_pwm highs over each played period; a period runs from two clocks
  // after the popping boundary up to one clock after the next boundary.
  always @(negedge clk) begin
    if (!aud_sd) begin
      if (win_on) discard = exp_q.pop_front();
      win_on = 1'b0;
      tick_d = 1'b0;
      pop_d  = 1'b0;
      acc    = 0;
    end else begin
      if (tick_d) begin
        if (win_on) begin
          acc += int'(aud_pwm);
          if (exp_q.size() == 0) check("sb_empty", 1, 0);
          else                   check("pwm_high", acc, int'(exp_q.pop_front()));
        end
        win_on = pop_d;
        acc    = 0;
      end else if (win_on) begin
        acc += int'(aud_pwm);
      end
      tick_d = period_tick;
      pop_d  = period_tick && !underrun;
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (aud_pwm) pwm_seen = 1'b1;
    end while (!period_tick && n < 40);
    if (!period_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic push_sample(input logic [SW-1:0] s);
    int n;
    in_data  = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", int'(in_ready), 1);
    exp_q.push_back(s);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n, u0;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b1; in_data = 4'd7;
    rst2 = 1'b1; en2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
    repeat (3) @(negedge clk);

    // Reset state, with a push attempted while reset is high
    check("rst_pwm", int'(aud_pwm), 0);
    check("rst_sd", int'(aud_sd), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_under", int'(underrun), 0);
    check("rst_ucnt", int'(underrun_cnt), 0);
    check("rst_level", int'(fifo_level), 0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(in_ready), 1);
    check("rst_no_push", int'(fifo_level), 0);

    // Test 1: enabled with an empty FIFO
    pwm_seen = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_tick(n);
      check("t1_gap", n, 15);
      check("t1_under", int'(underrun), 1);
      @(negedge clk);
      check("t1_ucnt", int'(underrun_cnt), i);
    end
    check("t1_pwm_idle", int'(pwm_seen), 0);

    // Test 2 / 4: fill, then hold a 5th push across the boundary
    push_sample(4'd4);
    push_sample(4'd0);
    push_sample(4'd15);
    push_sample(4'd8);
    check("t2_full_ready", int'(in_ready), 0);
    check("t2_full_level", int'(fifo_level), 4);
    in_data = 4'd3; in_valid = 1'b1;
    wait_tick(n);
    check("t4_bnd_ready", int'(in_ready), 0);
    check("t4_bnd_level", int'(fifo_level), 4);
    check("t4_bnd_under", int'(underrun), 0);
    @(negedge clk);
    check("t4_after_pop", int'(fifo_level), 3);
    check("t4_ready_back", int'(in_ready), 1);
    exp_q.push_back(4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_push_lands", int'(fifo_level), 4);
    drain();

    // Test 3: push on a boundary that finds the FIFO empty
    wait_tick(n);
    in_data = 4'd9; in_valid = 1'b1;
    check("t3_under", int'(underrun), 1);
    check("t3_level0", int'(fifo_level), 0);
    u0 = int'(underrun_cnt);
    exp_q.push_back(4'd9);
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_level1", int'(fifo_level), 1);
    check("t3_ucnt", int'(underrun_cnt), u0 + 1);
    wait_tick(n);
    check("t3_pop_gap", n, 15);
    check("t3_pop_no_under", int'(underrun), 0);

    // Simultaneous push and pop on a non-full FIFO keeps the level
    push_sample(4'd11);
    check("pushpop_level", int'(fifo_level), 1);
    push_sample(4'd6);
    check("level2", int'(fifo_level), 2);

    // Test 5: drop enable mid-period while sample 11 plays
    wait_tick(n);
    repeat (4) @(negedge clk);
    check("t5_pwm_high", int'(aud_pwm), 1);
    u0 = int'(underrun_cnt);
    enable = 1'b0;
    @(negedge clk);
    check("t5_pwm_off", int'(aud_pwm), 0);
    check("t5_sd_off", int'(aud_sd), 0);
    check("t5_level_kept", int'(fifo_level), 1);
    push_sample(4'd13);
    pwm_seen = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (period_tick || underrun || aud_pwm) n++;
    end
    check("t5_idle_quiet", n, 0);
    check("t5_level_push", int'(fifo_level), 2);
    check("t5_ucnt_kept", int'(underrun_cnt), u0);
    enable = 1'b1;
    wait_tick(n);
    check("t5_reen_gap", n, 15);
    check("t5_reen_pop", int'(underrun), 0);
    drain();

    // Test 6: 2-bit saturating counter, then a one-clock reset mid-period
    rst2 = 1'b0; en2 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!period_tick2 && n < 40);
      check("t6_gap", n, 15);
      check("t6_under", int'(underrun2), 1);
      @(negedge clk);
      check("t6_ucnt", int'(ucnt2), (i > 3) ? 3 : i);
    end
    repeat (5) @(negedge clk);
    rst2 = 1'b1; in_valid2 = 1'b1; in_data2 = 4'd5;
    @(negedge clk);
    rst2 = 1'b0; in_valid2 = 1'b0;
    check("t6_pwm", int'(aud_pwm2), 0);
    check("t6_sd", int'(aud_sd2), 0);
    check("t6_tick", int'(period_tick2), 0);
    check("t6_under0", int'(underrun2), 0);
    check("t6_ucnt0", int'(ucnt2), 0);
    check("t6_level0", int'(level2), 0);
    check("t6_ready", int'(in_ready2), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!period_tick2 && n < 40);
    check("t6_restart_gap", n, 15);

    check("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
